alu_req_arbiter: RTL
====================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one ALU (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, max cycles waiting for alu_done before abort.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester command pending.
REQ-006 The block SHALL have port req_ready  output  N_REQ  one-hot grant; command accepted at posedge where req_valid[i] & req_ready[i].
REQ-007 The block SHALL have port req_op  input  8*N_REQ  opcode per requester (0 nop .. 10 wmr).
REQ-008 The block SHALL have ports req_a, req_b  input  32*N_REQ  operands per requester.
REQ-009 The block SHALL have ports req_sv, req_op_prefix  input  N_REQ  signed-mode and prefix flags per requester.
REQ-010 The block SHALL have ports alu_start (output, 1), alu_op (output, 8), alu_a, alu_b (output, 32), alu_sv, alu_op_prefix (output, 1)  ALU command side.
REQ-011 The block SHALL have ports alu_done (input, 1), alu_result (input, 64), alu_err (input, 8), alu_gp (input, 1)  ALU response side.
REQ-012 The block SHALL have ports rsp_valid (output, 1), rsp_id (output, clog2(N_REQ)), rsp_result (output, 64), rsp_err (output, 8), rsp_gp (output, 1)  response broadcast.
REQ-013 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP, DRAIN.
REQ-015 In IDLE with any req_valid set, req_ready SHALL assert combinationally for exactly one winner; operands, flags and winner index latched at that posedge; next state ISSUE.
REQ-016 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ; last_grant updates on each acceptance.
REQ-017 req_ready SHALL be all-zero outside IDLE and in IDLE when no req_valid is set.
REQ-018 In ISSUE, alu_start SHALL be 1 (registered) and alu_op/a/b/sv/op_prefix SHALL hold the latched values unchanged.
REQ-019 At the posedge where alu_done=1 in ISSUE, alu_result/err/gp SHALL be captured; next cycle state RESP, alu_start=0.
REQ-020 RESP SHALL last exactly one cycle with rsp_valid=1, rsp_id=winner and the captured values; next state DRAIN.
REQ-021 DRAIN SHALL hold until alu_done is sampled 0, then go to IDLE; a new grant is never issued while alu_done=1.
REQ-022 Opcode > 10 SHALL NOT be issued: accepted, then RESP with rsp_err=8'hFE, rsp_result=0, rsp_gp=0; alu_start stays 0.
REQ-023 A 16-bit cycle counter SHALL clear on ISSUE entry and increment each ISSUE cycle; when it reaches TIMEOUT without alu_done, the block SHALL go to RESP with rsp_err=8'hFF, rsp_result=0, rsp_gp=0.
REQ-024 Minimum latency, acceptance to rsp_valid, SHALL be 3 cycles (ALU done on the first ISSUE cycle).
REQ-025 rsp_* SHALL be zero whenever rsp_valid=0.
REQ-026 A requester dropping req_valid before grant SHALL simply lose arbitration; no partial transaction.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, alu_start=0, all alu_* outputs 0, req_ready=0, rsp_*=0, busy=0, counter 0, last_grant=N_REQ-1 (requester 0 wins first).
REQ-028 Reset mid-transaction SHALL discard the transaction with no rsp_valid; after release, the block SHALL wait for alu_done=0 (DRAIN behaviour) before the first grant.

Verification
REQ-029 Single req: req_valid[2]=1, op=1, A=5, B=7; ALU done after 2 cycles with result 12 -> alu_a=5, alu_b=7 during ISSUE; rsp_valid 1 cycle, rsp_id=2, rsp_result=12.
REQ-030 All four request continuously after reset -> grant order 0,1,2,3,0; each rsp_id matches its grant.
REQ-031 op=8'd11 from requester 1 -> no alu_start; rsp_err=8'hFE, rsp_id=1, 2 cycles after acceptance.
REQ-032 ALU never asserts done, TIMEOUT=10 -> alu_start high 10 cycles, then rsp_err=8'hFF, alu_start=0.
REQ-033 reset asserted in ISSUE -> alu_start 0 same cycle, no rsp_valid; held alu_done=1 after release blocks grants until it drops.
REQ-034 alu_done held high 3 cycles after capture -> exactly one rsp_valid; next grant only after alu_done=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between N_REQ requesters.
// One command in flight: grant, issue, one-cycle response, drain.
module alu_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [8*N_REQ-1:0]       req_op,
  input  logic [32*N_REQ-1:0]      req_a,
  input  logic [32*N_REQ-1:0]      req_b,
  input  logic [N_REQ-1:0]         req_sv,
  input  logic [N_REQ-1:0]         req_op_prefix,
  output logic                     alu_start,
  output logic [7:0]               alu_op,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic                     alu_sv,
  output logic                     alu_op_prefix,
  input  logic                     alu_done,
  input  logic [63:0]              alu_result,
  input  logic [7:0]               alu_err,
  input  logic                     alu_gp,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [63:0]              rsp_result,
  output logic [7:0]               rsp_err,
  output logic                     rsp_gp,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] OP_MAX = 8'd10;
  localparam logic [7:0] ERR_BAD = 8'hFE;
  localparam logic [7:0] ERR_TMO = 8'hFF;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [7:0]  op_arr [N_REQ];
  logic [31:0] a_arr  [N_REQ];
  logic [31:0] b_arr  [N_REQ];

  logic [IW-1:0] last_grant;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  logic          accept;
  logic          bad;
  logic          tmo;
  logic [15:0]   cnt;
  logic [63:0]   cap_result;
  logic [7:0]    cap_err;
  logic          cap_gp;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[8*g +: 8];
    assign a_arr[g]  = req_a[32*g +: 32];
    assign b_arr[g]  = req_b[32*g +: 32];
  end

  // Search starts one past the previous winner so everyone gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept = (state == IDLE) && !reset
               && !alu_done && found;
  assign req_ready = accept ? (N_REQ'(1) << win) : '0;
  assign tmo = (cnt == TMO_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   if (bad || alu_done || tmo) state_nx = RESP;
      RESP:    state_nx = DRAIN;
      DRAIN:   if (!alu_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant    <= IW'(N_REQ - 1);
      owner         <= '0;
      alu_start     <= 1'b0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sv        <= 1'b0;
      alu_op_prefix <= 1'b0;
      bad           <= 1'b0;
      cnt           <= '0;
      cap_result    <= '0;
      cap_err       <= '0;
      cap_gp        <= 1'b0;
    end else begin
      if (accept) begin
        last_grant    <= win;
        owner         <= win;
        alu_op        <= op_arr[win];
        alu_a         <= a_arr[win];
        alu_b         <= b_arr[win];
        alu_sv        <= req_sv[win];
        alu_op_prefix <= req_op_prefix[win];
        bad           <= op_arr[win] > OP_MAX;
        alu_start     <= op_arr[win] <= OP_MAX;
        cnt           <= '0;
        cap_result    <= '0;
        cap_gp        <= 1'b0;
        cap_err       <= (op_arr[win] > OP_MAX) ? ERR_BAD : 8'h00;
      end
      // Illegal opcodes keep the error preset at acceptance.
      if (state == ISSUE) begin
        if (bad) begin
          cnt <= cnt;
        end else if (alu_done) begin
          cap_result <= alu_result;
          cap_err    <= alu_err;
          cap_gp     <= alu_gp;
        end else if (tmo) begin
          cap_err <= ERR_TMO;
        end else begin
          cnt <= cnt + 16'd1;
        end
        if (state_nx != ISSUE) alu_start <= 1'b0;
      end
    end
  end

  assign rsp_valid  = (state == RESP);
  assign rsp_id     = rsp_valid ? owner : '0;
  assign rsp_result = rsp_valid ? cap_result : '0;
  assign rsp_err    = rsp_valid ? cap_err : '0;
  assign rsp_gp     = rsp_valid ? cap_gp : 1'b0;
  assign busy       = (state != IDLE);

endmodule
